// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: control-bundle bit
// positions, the default datapath width and the register-number width.
package mips_pkg;

    // Default datapath / address word width
    localparam int DATA_W     = 32;

    // Register-file address width (32 architectural registers)
    localparam int REG_ADDR_W = 5;

    // Bit positions inside the write-back control bundle {regwrite, memtoreg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Bit positions inside the memory control bundle {branch, memread, memwrite}
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

endpackage : mips_pkg

// File: rtl/data_mem.sv
// Word-addressed synchronous single-port data memory.
// Reads are registered and read-before-write: a read and a write to the same
// word on the same edge return the old contents while the new value is
// stored. The registered read port clears asynchronously on reset and
// returns zero on any cycle without a read. The array itself is never
// cleared by reset; its power-on contents are zero.
module data_mem
    import mips_pkg::*;
#(
    parameter int  DATA_W = mips_pkg::DATA_W,
    parameter int  DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata_r;

    // Array write port; the caller already folds reset into we
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port: old contents on a collision, zero when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= '0;
        end
    end

    assign rdata = rdata_r;

endmodule : data_mem

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline latch of the 5-stage MIPS pipeline.
// Resolves the branch decision combinationally, performs the data-memory
// access and registers everything the write-back stage consumes.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- adds misalign_q and
// suppresses misaligned stores / zeroes misaligned loads. Without it the
// low two address bits are ignored and the access truncates to the word.
module mem_wb_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int DEPTH  = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      wb_ctlout,
    input  logic [2:0]                      m_ctlout,
    input  logic [DATA_W-1:0]               add_result,
    input  logic [DATA_W-1:0]               alu_result,
    input  logic [DATA_W-1:0]               rdata2out,
    input  logic                            zero,
    input  logic [mips_pkg::REG_ADDR_W-1:0] five_bit_muxout,
    output logic                            pcsrc,
    output logic [DATA_W-1:0]               branch_target,
    output logic [1:0]                      wb_ctl_q,
    output logic [DATA_W-1:0]               read_data_q,
    output logic [DATA_W-1:0]               alu_result_q,
    output logic [mips_pkg::REG_ADDR_W-1:0] dest_reg_q
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                            misalign_q
`endif
);

    import mips_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]     word_idx_s;
    logic                  mem_we_s;
    logic                  mem_re_s;
    logic                  misalign_s;
    logic [1:0]            wb_ctl_r;
    logic [DATA_W-1:0]     alu_result_r;
    logic [REG_ADDR_W-1:0] dest_reg_r;
    logic                  unused_addr_bits_s;

    // Branch decision and target are needed by IF in the same cycle
    assign pcsrc         = m_ctlout[M_BRANCH] & zero;
    assign branch_target = add_result;

    // Word index; upper bits drop out so the address wraps modulo DEPTH
    assign word_idx_s = alu_result[ADDR_W+1:2];
    assign misalign_s = (alu_result[1:0] != 2'b00);

    // Address bits that do not select a word are deliberately discarded
    assign unused_addr_bits_s = &{1'b0, alu_result[DATA_W-1:ADDR_W+2], misalign_s};

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned accesses never touch memory; a blocked load reads back zero
    assign mem_we_s = m_ctlout[M_MEMWRITE] & ~reset & ~misalign_s;
    assign mem_re_s = m_ctlout[M_MEMREAD] & ~misalign_s;
`else
    // Byte offset ignored: the access is truncated to the containing word
    assign mem_we_s = m_ctlout[M_MEMWRITE] & ~reset;
    assign mem_re_s = m_ctlout[M_MEMREAD];
`endif

    data_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_data_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (word_idx_s),
        .wdata (rdata2out),
        .rdata (read_data_q)
    );

    // MEM/WB latch: free-running, no stall, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ctl_r     <= 2'b00;
            alu_result_r <= '0;
            dest_reg_r   <= '0;
        end else begin
            wb_ctl_r     <= wb_ctlout;
            alu_result_r <= alu_result;
            dest_reg_r   <= five_bit_muxout;
        end
    end

    assign wb_ctl_q     = wb_ctl_r;
    assign alu_result_q = alu_result_r;
    assign dest_reg_q   = dest_reg_r;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_r;

    // Flag any memory access whose byte offset is nonzero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= (m_ctlout[M_MEMREAD] | m_ctlout[M_MEMWRITE]) & misalign_s;
        end
    end

    assign misalign_q = misalign_r;
`endif

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (DEPTH=256, DATA_W=32).
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] add_result;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic        zero;
    logic [4:0]  five_bit_muxout;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic [1:0]  wb_ctl_q;
    logic [31:0] read_data_q;
    logic [31:0] alu_result_q;
    logic [4:0]  dest_reg_q;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_q;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_wb_stage dut (
        .clk             (clk),
        .reset           (reset),
        .wb_ctlout       (wb_ctlout),
        .m_ctlout        (m_ctlout),
        .add_result      (add_result),
        .alu_result      (alu_result),
        .rdata2out       (rdata2out),
        .zero            (zero),
        .five_bit_muxout (five_bit_muxout),
        .pcsrc           (pcsrc),
        .branch_target   (branch_target),
        .wb_ctl_q        (wb_ctl_q),
        .read_data_q     (read_data_q),
        .alu_result_q    (alu_result_q),
        .dest_reg_q      (dest_reg_q)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_q      (misalign_q)
`endif
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wb_ctlout = 2'b00; m_ctlout = 3'b000; add_result = 32'h0;
        alu_result = 32'h0; rdata2out = 32'h0; zero = 1'b0; five_bit_muxout = 5'd0;
        step(); step();
        reset = 1'b0;
        wb_ctlout = 2'b11; alu_result = 32'h1234; five_bit_muxout = 5'd7;
        step();
        n_cmp++;
        if (alu_result_q !== 32'h1234 || wb_ctl_q !== 2'b11 || dest_reg_q !== 5'd7) begin
            n_bad++;
            $display("FAIL first_capture: got alu=%h wb=%b dst=%0d want alu=00001234 wb=11 dst=7",
                     alu_result_q, wb_ctl_q, dest_reg_q);
        end
        // assert reset mid-cycle, check before the next edge
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (alu_result_q !== 32'h0 || wb_ctl_q !== 2'b00 || dest_reg_q !== 5'd0 || read_data_q !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: got alu=%h wb=%b dst=%0d rd=%h want all zero",
                     alu_result_q, wb_ctl_q, dest_reg_q, read_data_q);
        end
        // a store presented while reset is high must not land
        m_ctlout = 3'b001; alu_result = 32'hC; rdata2out = 32'h55AA55AA;
        step();
        reset = 1'b0;
        m_ctlout = 3'b010;
        step();
        n_cmp++;
        if (read_data_q !== 32'h0) begin
            n_bad++;
            $display("FAIL write_in_reset: got %h want 00000000", read_data_q);
        end
    endtask

    task automatic test_store_load();
        m_ctlout = 3'b001; alu_result = 32'h8; rdata2out = 32'hDEADBEEF;
        step();
        n_cmp++;
        if (read_data_q !== 32'h0) begin
            n_bad++;
            $display("FAIL store_no_read: got %h want 00000000", read_data_q);
        end
        m_ctlout = 3'b010; alu_result = 32'h8; rdata2out = 32'h0;
        step();
        n_cmp++;
        if (read_data_q !== 32'hDEADBEEF || alu_result_q !== 32'h8) begin
            n_bad++;
            $display("FAIL store_load: got rd=%h alu=%h want rd=deadbeef alu=00000008",
                     read_data_q, alu_result_q);
        end
    endtask

    task automatic test_branch();
        m_ctlout = 3'b100; zero = 1'b1; add_result = 32'h40;
        #1;
        n_cmp++;
        if (pcsrc !== 1'b1 || branch_target !== 32'h40) begin
            n_bad++;
            $display("FAIL branch_taken: got pcsrc=%b tgt=%h want 1 00000040", pcsrc, branch_target);
        end
        zero = 1'b0;
        #1;
        n_cmp++;
        if (pcsrc !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_not_taken: got %b want 0", pcsrc);
        end
        m_ctlout = 3'b000; zero = 1'b1; add_result = 32'h1234_5678;
        #1;
        n_cmp++;
        if (pcsrc !== 1'b0 || branch_target !== 32'h12345678) begin
            n_bad++;
            $display("FAIL no_branch_zero: got pcsrc=%b tgt=%h want 0 12345678", pcsrc, branch_target);
        end
        zero = 1'b0;
    endtask

    task automatic test_passthrough();
        // memread high first so a nonzero read_data_q must fall back to zero
        m_ctlout = 3'b010; alu_result = 32'h8;
        step();
        wb_ctlout = 2'b10; alu_result = 32'h0F; five_bit_muxout = 5'b11111; m_ctlout = 3'b000;
        step();
        n_cmp++;
        if (wb_ctl_q !== 2'b10 || alu_result_q !== 32'h0F || dest_reg_q !== 5'd31 || read_data_q !== 32'h0) begin
            n_bad++;
            $display("FAIL passthrough: got wb=%b alu=%h dst=%0d rd=%h want 10 0000000f 31 00000000",
                     wb_ctl_q, alu_result_q, dest_reg_q, read_data_q);
        end
        wb_ctlout = 2'b01; alu_result = 32'hFFFF_0000; five_bit_muxout = 5'd4;
        step();
        n_cmp++;
        if (wb_ctl_q !== 2'b01 || alu_result_q !== 32'hFFFF0000 || dest_reg_q !== 5'd4) begin
            n_bad++;
            $display("FAIL passthrough2: got wb=%b alu=%h dst=%0d want 01 ffff0000 4",
                     wb_ctl_q, alu_result_q, dest_reg_q);
        end
    endtask

    task automatic test_wrap();
        m_ctlout = 3'b001; alu_result = 32'h400; rdata2out = 32'hCAFE0001;
        step();
        m_ctlout = 3'b010; alu_result = 32'h0;
        step();
        n_cmp++;
        if (read_data_q !== 32'hCAFE0001) begin
            n_bad++;
            $display("FAIL wrap_0x400: got %h want cafe0001", read_data_q);
        end
        // top word: 0x3FC and 0xFFFFFFFC share index 255
        m_ctlout = 3'b001; alu_result = 32'hFFFF_FFFC; rdata2out = 32'h0BAD_F00D;
        step();
        m_ctlout = 3'b010; alu_result = 32'h3FC;
        step();
        n_cmp++;
        if (read_data_q !== 32'h0BADF00D) begin
            n_bad++;
            $display("FAIL wrap_top: got %h want 0badf00d", read_data_q);
        end
    endtask

    task automatic test_read_before_write();
        m_ctlout = 3'b011; alu_result = 32'h8; rdata2out = 32'h1234_5678;
        step();
        n_cmp++;
        if (read_data_q !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL rbw_old: got %h want deadbeef", read_data_q);
        end
        m_ctlout = 3'b010;
        step();
        n_cmp++;
        if (read_data_q !== 32'h12345678) begin
            n_bad++;
            $display("FAIL rbw_new: got %h want 12345678", read_data_q);
        end
    endtask

    task automatic test_misalign();
        m_ctlout = 3'b001; alu_result = 32'h4; rdata2out = 32'hA5A5A5A5;
        step();
        m_ctlout = 3'b001; alu_result = 32'h6; rdata2out = 32'h0000FFFF;
        step();
`ifdef MEM_MISALIGN_TRAP_EN
        n_cmp++;
        if (misalign_q !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign_flag: got %b want 1", misalign_q);
        end
        m_ctlout = 3'b010; alu_result = 32'h4;
        step();
        n_cmp++;
        if (read_data_q !== 32'hA5A5A5A5 || misalign_q !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_store_blocked: got rd=%h flag=%b want a5a5a5a5 0",
                     read_data_q, misalign_q);
        end
        m_ctlout = 3'b010; alu_result = 32'h5;
        step();
        n_cmp++;
        if (read_data_q !== 32'h0 || misalign_q !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign_load: got rd=%h flag=%b want 00000000 1", read_data_q, misalign_q);
        end
        m_ctlout = 3'b000; alu_result = 32'h7;
        step();
        n_cmp++;
        if (misalign_q !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_no_access: got %b want 0", misalign_q);
        end
`else
        m_ctlout = 3'b010; alu_result = 32'h4;
        step();
        n_cmp++;
        if (read_data_q !== 32'h0000FFFF) begin
            n_bad++;
            $display("FAIL truncated_store: got %h want 0000ffff", read_data_q);
        end
        m_ctlout = 3'b010; alu_result = 32'h7;
        step();
        n_cmp++;
        if (read_data_q !== 32'h0000FFFF) begin
            n_bad++;
            $display("FAIL truncated_load: got %h want 0000ffff", read_data_q);
        end
`endif
        m_ctlout = 3'b000;
    endtask

    task automatic test_back_to_back();
        // consecutive stores then consecutive loads, one word per cycle
        for (int i = 0; i < 4; i++) begin
            m_ctlout = 3'b001; alu_result = 32'h100 + 32'(i * 4); rdata2out = 32'h1111_0000 + 32'(i);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            m_ctlout = 3'b010; alu_result = 32'h100 + 32'(i * 4);
            step();
            n_cmp++;
            if (read_data_q !== 32'h1111_0000 + 32'(i)) begin
                n_bad++;
                $display("FAIL b2b_load%0d: got %h want %h", i, read_data_q, 32'h1111_0000 + 32'(i));
            end
        end
        m_ctlout = 3'b000;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_branch();
        test_passthrough();
        test_wrap();
        test_read_before_write();
        test_misalign();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_wb_stage

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline latch of the 5-stage MIPS pipeline; sits directly downstream of the EX/MEM latch and consumes its outputs.
- Holds the word-addressed data memory, resolves the branch decision (pcsrc), and registers everything the write-back stage needs.
- Write-back mux and register file sit downstream and are out of scope.

Parameters:
- DATA_W, 32, data/address word width.
- DEPTH, 256, data memory depth in 32-bit words (power of two).
- ADDR_W, $clog2(DEPTH), word-index width, derived and not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wb_ctlout  in  2  {regwrite, memtoreg} from EX/MEM.
- m_ctlout  in  3  {branch, memread, memwrite} from EX/MEM.
- add_result  in  32  branch target from EX/MEM.
- alu_result  in  32  ALU result / byte address from EX/MEM.
- rdata2out  in  32  store data from EX/MEM.
- zero  in  1  ALU zero flag from EX/MEM.
- five_bit_muxout  in  5  destination register number from EX/MEM.
- pcsrc  out  1  branch taken (combinational).
- branch_target  out  32  pass-through of add_result (combinational).
- wb_ctl_q  out  2  registered wb_ctlout.
- read_data_q  out  32  registered memory read data.
- alu_result_q  out  32  registered alu_result.
- dest_reg_q  out  5  registered five_bit_muxout.

Behaviour:
- pcsrc = m_ctlout[2] & zero. Purely combinational, same cycle as inputs. branch_target = add_result.
- Word index = alu_result[ADDR_W+1:2]. Upper address bits above the index are ignored, so the address wraps modulo DEPTH words. alu_result[1:0] is ignored unless the optional feature is enabled.
- Write: at rising clk, if memwrite=1 and reset=0, mem[index] <= rdata2out.
- Read: at rising clk, if memread=1, read_data_q <= mem[index]; if memread=0, read_data_q <= 0. Latency is 1 cycle, arriving with alu_result_q.
- Read and write to the same index in the same cycle (memread=memwrite=1, illegal from decode but must be defined): read_data_q gets the OLD contents (read-before-write) and memory gets the new value.
- Every rising clk: wb_ctl_q <= wb_ctlout, alu_result_q <= alu_result, dest_reg_q <= five_bit_muxout. There is no stall or enable; the latch updates every cycle.
- Reset (async, immediate on assertion, regardless of clk): wb_ctl_q=0, read_data_q=0, alu_result_q=0, dest_reg_q=0.
  - Memory contents are NOT cleared by reset.
  - No write occurs on any edge while reset=1.
  - Reset asserted mid-write cycle suppresses that write.
- First rising edge after reset deassertion captures inputs normally.
- Power-on memory contents are zero (array initialised at elaboration).

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Extra output port misalign_q (1 bit, reset 0).
  - misalign_q <= (memread|memwrite) & (alu_result[1:0]!=0) each cycle.
  - A misaligned store is suppressed (memory unchanged).
  - A misaligned load returns read_data_q=0.
- Not defined:
  - Port absent.
  - alu_result[1:0] silently ignored (access is truncated to the word).

Decomposition:
- Shared package mips_pkg holds:
  - bit-position constants WB_REGWRITE=1, WB_MEMTOREG=0, M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0;
  - DATA_W default;
  - REG_ADDR_W=5.
- One natural sub-module, data_mem: a synchronous single-port RAM with read-before-write and write enable, parameterised by DEPTH/DATA_W.
- The MEM/WB latch and pcsrc logic stay in mem_wb_stage.

Test Plan:
- Reset: assert reset mid-cycle with nonzero inputs -> all _q outputs 0 immediately, before the next clk edge.
- Store then load:
  - cycle 1: m_ctlout=3'b001, alu_result=32'h8, rdata2out=32'hDEADBEEF;
  - cycle 2: m_ctlout=3'b010, alu_result=32'h8;
  - -> read_data_q=32'hDEADBEEF after the cycle-2 edge.
- Branch: m_ctlout=3'b100, zero=1, add_result=32'h40 -> pcsrc=1 and branch_target=32'h40 same cycle; zero=0 -> pcsrc=0.
- Pass-through: wb_ctlout=2'b10, alu_result=32'h0F, five_bit_muxout=5'b11111 -> next edge wb_ctl_q=2'b10, alu_result_q=32'h0F, dest_reg_q=5'd31, read_data_q=0 (memread=0).
- Wrap and read-before-write:
  - with DEPTH=256, a store to alu_result=32'h400 is read back via alu_result=32'h0;
  - simultaneous read and write to the same index returns the old value.
- With MEM_MISALIGN_TRAP_EN: store to alu_result=32'h6 -> misalign_q=1, word 1 unchanged; aligned access -> misalign_q=0.
